pkt_shaper: RTL and testbench
=============================

Name: pkt_shaper

Overview:
- Upstream producer stage for the 8-bit byte FIFO.
- Accepts length-announced packets from a source, frames them (SOF, length, payload, optional checksum) and writes them into the FIFO through its din/wr_en/full interface.
- Admission is rate-limited by a token bucket, so traffic entering the FIFO is shaped before the FIFO applies its own read-side delays.

Parameters:
BUCKET_SIZE, 32, bucket capacity in tokens (1 token = 1 FIFO byte); legal 4..255
RATE_DIV, 4, clock cycles per refill tick; legal >=1
TOKENS_PER_TICK, 1, tokens added per refill tick
SOF_BYTE, 8'h7E, start-of-frame marker byte

Ports:
clk  in  1  system clock, all state on posedge
srst  in  1  reset, asynchronous, active-high
pkt_start  in  1  request to start a packet; pkt_len valid while high
pkt_len  in  8  payload length in bytes (0..255)
pkt_accept  out  1  one-cycle pulse: request admitted, tokens debited
pkt_drop  out  1  one-cycle pulse: request rejected as oversize
in_data  in  8  payload byte
in_valid  in  1  payload byte valid
in_ready  out  1  payload byte consumed this cycle when in_valid & in_ready
fifo_din  out  8  byte to FIFO
fifo_wr_en  out  1  FIFO write strobe
fifo_full  in  1  FIFO full flag
busy  out  1  high in any state other than IDLE
tokens  out  8  current token count

Behaviour:
- Reset (async, srst=1): state IDLE; tokens=BUCKET_SIZE; refill divider=0; byte counter=0; checksum=0; all outputs 0 except tokens.
- Reset mid-packet: frame aborted immediately. Bytes already written stay in the FIFO, which shares srst and clears itself.
- Frame cost OVH = 3 (SOF, LEN, CSUM); 2 without the optional feature. All cost arithmetic is 9-bit: cost = pkt_len + OVH.
- States: IDLE, WAIT_TOK, SOF, LEN, PAYLOAD, CSUM.
- IDLE:
  - If pkt_start and cost > BUCKET_SIZE: pulse pkt_drop; stay IDLE.
  - Else if pkt_start: latch pkt_len; go to WAIT_TOK.
- WAIT_TOK: when tokens >= cost, pulse pkt_accept, debit cost, go to SOF. Evaluated every cycle, including the cycle after entry.
- SOF, LEN, CSUM:
  - fifo_wr_en = !fifo_full (combinational).
  - fifo_din = SOF_BYTE / latched len / checksum respectively.
  - Advance only on a cycle where the write occurs.
- LEN with len == 0 goes straight to CSUM.
- PAYLOAD:
  - in_ready = !fifo_full; fifo_wr_en = in_valid & !fifo_full; fifo_din = in_data. Zero-latency pass-through.
  - On each transfer: checksum ^= in_data; count++.
  - After len transfers go to CSUM, or to IDLE without the optional feature.
- CSUM: after its write, return to IDLE and clear checksum.
- Full back-pressure: whenever fifo_full=1, fifo_wr_en=0 and in_ready=0. No byte is lost or duplicated, and the state holds.
- fifo_wr_en is 0 in IDLE and WAIT_TOK. in_ready is 0 outside PAYLOAD.
- Token refill:
  - Divider counts 0..RATE_DIV-1; on wrap, tokens += TOKENS_PER_TICK, saturating at BUCKET_SIZE.
  - Refill on the same cycle as a debit: tokens <= min(tokens - cost + refill, BUCKET_SIZE).
  - The debit never underflows, because it only happens when tokens >= cost.
- pkt_start while busy is ignored; the source must hold it until pkt_accept or pkt_drop.
- Throughput: one FIFO byte per cycle when not full.

Optional Feature:
- Macro: PKT_SHAPER_CSUM_EN.
- Defined: OVH=3; the CSUM state emits the XOR of all payload bytes (0x00 for an empty payload).
- Undefined: OVH=2; CSUM state and checksum register are removed; PAYLOAD (or LEN when len==0) returns directly to IDLE.

Test Plan:
- Reset, then pkt_len=4 with payload 11,22,33,44 and fifo_full=0 → FIFO writes 7E,04,11,22,33,44,44 on 7 consecutive cycles; pkt_accept once; tokens 32→25 (plus any refill).
- pkt_len=30 (cost 33 > 32) → pkt_drop pulses one cycle; no fifo_wr_en; state stays IDLE; tokens unchanged.
- Two back-to-back pkt_len=26 requests (cost 29) → second stays in WAIT_TOK; its pkt_accept fires on the first cycle tokens >= 29; tokens then drop by 29; refill is exactly 1 per 4 cycles, capped at 32.
- Mid-payload fifo_full=1 for 5 cycles with in_valid=1 → in_ready=0 and fifo_wr_en=0 for those 5 cycles; the FIFO byte sequence matches the input exactly.
- Assert srst during PAYLOAD byte 2 → same cycle: busy=0, in_ready=0, fifo_wr_en=0, tokens=32; the next packet frames normally from SOF.
- pkt_len=0 → FIFO writes 7E,00,00 with the feature defined, or 7E,00 without it.

Source files
------------

// File: rtl/pkt_shaper.sv
// Token-bucket shaper framing packets (SOF, LEN, payload[, CSUM]) into a byte FIFO; payload is zero-latency pass-through.
// fifo_full stalls every write and in_ready in the same cycle; PKT_SHAPER_CSUM_EN adds the XOR checksum trailer.
module pkt_shaper #(
  parameter int          BUCKET_SIZE     = 32,
  parameter int          RATE_DIV        = 4,
  parameter int          TOKENS_PER_TICK = 1,
  parameter logic [7:0]  SOF_BYTE        = 8'h7E
) (
  input  logic       clk,
  input  logic       srst,
  input  logic       pkt_start,
  input  logic [7:0] pkt_len,
  output logic       pkt_accept,
  output logic       pkt_drop,
  input  logic [7:0] in_data,
  input  logic       in_valid,
  output logic       in_ready,
  output logic [7:0] fifo_din,
  output logic       fifo_wr_en,
  input  logic       fifo_full,
  output logic       busy,
  output logic [7:0] tokens
);

`ifdef PKT_SHAPER_CSUM_EN
  localparam int OVH = 3;
`else
  localparam int OVH = 2;
`endif
  localparam int DW = (RATE_DIV > 1) ? $clog2(RATE_DIV) : 1;

  typedef enum logic [2:0] {
    IDLE, WAIT_TOK, SOF, LEN, PAYLOAD
`ifdef PKT_SHAPER_CSUM_EN
    , CSUM
`endif
  } state_t;

`ifdef PKT_SHAPER_CSUM_EN
  localparam state_t END_ST = CSUM;
`else
  localparam state_t END_ST = IDLE;
`endif

  state_t         state_q, state_d;
  logic [7:0]     len_q, len_d;
  logic [7:0]     cnt_q, cnt_d;
  logic [7:0]     tok_q, tok_d;
  logic [DW-1:0]  div_q, div_d;
`ifdef PKT_SHAPER_CSUM_EN
  logic [7:0]     csum_q, csum_d;
`endif

  logic [8:0] req_cost, lat_cost;
  logic       tick;
  logic [9:0] tok_sum;

  assign req_cost = {1'b0, pkt_len} + 9'(OVH);
  assign lat_cost = {1'b0, len_q} + 9'(OVH);
  assign tick     = (div_q == DW'(RATE_DIV - 1));
  assign div_d    = tick ? '0 : div_q + DW'(1);

  // Debit and refill combine in one wider sum, then saturate at the bucket size.
  assign tok_sum = {2'b00, tok_q}
                 - (pkt_accept ? {1'b0, lat_cost} : 10'd0)
                 + (tick ? 10'(TOKENS_PER_TICK) : 10'd0);
  assign tok_d   = (tok_sum > 10'(BUCKET_SIZE)) ? 8'(BUCKET_SIZE) : tok_sum[7:0];

  assign busy   = (state_q != IDLE);
  assign tokens = tok_q;

  always_comb begin
    state_d    = state_q;
    len_d      = len_q;
    cnt_d      = cnt_q;
`ifdef PKT_SHAPER_CSUM_EN
    csum_d     = csum_q;
`endif
    fifo_din   = 8'h00;
    fifo_wr_en = 1'b0;
    in_ready   = 1'b0;
    pkt_accept = 1'b0;
    pkt_drop   = 1'b0;
    case (state_q)
      IDLE: begin
        if (pkt_start && !srst) begin
          if (req_cost > 9'(BUCKET_SIZE)) begin
            pkt_drop = 1'b1;
          end else begin
            len_d   = pkt_len;
            state_d = WAIT_TOK;
          end
        end
      end
      WAIT_TOK: begin
        if ({1'b0, tok_q} >= lat_cost) begin
          pkt_accept = 1'b1;
          state_d    = SOF;
        end
      end
      SOF: begin
        fifo_din   = SOF_BYTE;
        fifo_wr_en = !fifo_full;
        if (!fifo_full) state_d = LEN;
      end
      LEN: begin
        fifo_din   = len_q;
        fifo_wr_en = !fifo_full;
        if (!fifo_full) state_d = (len_q == 8'd0) ? END_ST : PAYLOAD;
      end
      PAYLOAD: begin
        in_ready   = !fifo_full;
        fifo_din   = in_data;
        fifo_wr_en = in_valid && !fifo_full;
        if (fifo_wr_en) begin
`ifdef PKT_SHAPER_CSUM_EN
          csum_d = csum_q ^ in_data;
`endif
          if (cnt_q == len_q - 8'd1) begin
            cnt_d   = 8'd0;
            state_d = END_ST;
          end else begin
            cnt_d = cnt_q + 8'd1;
          end
        end
      end
`ifdef PKT_SHAPER_CSUM_EN
      CSUM: begin
        fifo_din   = csum_q;
        fifo_wr_en = !fifo_full;
        if (!fifo_full) begin
          csum_d  = 8'h00;
          state_d = IDLE;
        end
      end
`endif
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge srst) begin
    if (srst) begin
      state_q <= IDLE;
      len_q   <= 8'd0;
      cnt_q   <= 8'd0;
      tok_q   <= 8'(BUCKET_SIZE);
      div_q   <= '0;
`ifdef PKT_SHAPER_CSUM_EN
      csum_q  <= 8'h00;
`endif
    end else begin
      state_q <= state_d;
      len_q   <= len_d;
      cnt_q   <= cnt_d;
      tok_q   <= tok_d;
      div_q   <= div_d;
`ifdef PKT_SHAPER_CSUM_EN
      csum_q  <= csum_d;
`endif
    end
  end

endmodule

// File: tb/tb_pkt_shaper.sv
// Randomized bench for pkt_shaper against a frame-queue / token-bucket reference model.
module tb_pkt_shaper;
  localparam int BUCKET = 32;
  localparam int RDIV   = 4;
  localparam int TPT    = 1;
  localparam logic [7:0] SOFB = 8'h7E;
`ifdef PKT_SHAPER_CSUM_EN
  localparam int OVH = 3;
`else
  localparam int OVH = 2;
`endif

  logic       clk, srst;
  logic       pkt_start, pkt_accept, pkt_drop;
  logic [7:0] pkt_len, in_data, fifo_din, tokens;
  logic       in_valid, in_ready, fifo_wr_en, fifo_full, busy;

  pkt_shaper #(.BUCKET_SIZE(BUCKET), .RATE_DIV(RDIV), .TOKENS_PER_TICK(TPT), .SOF_BYTE(SOFB)) dut (
    .clk(clk), .srst(srst), .pkt_start(pkt_start), .pkt_len(pkt_len),
    .pkt_accept(pkt_accept), .pkt_drop(pkt_drop), .in_data(in_data),
    .in_valid(in_valid), .in_ready(in_ready), .fifo_din(fifo_din),
    .fifo_wr_en(fifo_wr_en), .fifo_full(fifo_full), .busy(busy), .tokens(tokens)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: token bucket in plain integers, frames as expected byte lists.
  int         m_tok, m_div, m_len;
  bit         m_wait;
  logic [7:0] frame[$];
  int         m_ptr;
  bit         drv_req;
  int         drv_len;
  logic [7:0] drv_pay[$];
  logic [7:0] m_pay[$];
  int         full_pct, valid_pct, full_force;

  task automatic model_reset();
    m_tok = BUCKET; m_div = 0; m_wait = 0; m_len = 0;
    frame.delete(); m_ptr = 0; drv_req = 0; full_force = 0;
  endtask

  task automatic step();
    bit active, is_pay, busy_e, drop_e, acc_e, wr_e, rdy_e;
    int debit, t;
    logic [7:0] cs;
    @(negedge clk);
    active = (frame.size() > 0) && (m_ptr < frame.size());
    is_pay = active && (m_ptr >= 2) && (m_ptr < 2 + m_len);
    pkt_start = drv_req;
    pkt_len   = 8'(drv_len);
    if (full_force > 0) begin
      fifo_full = 1'b1;
      full_force--;
    end else begin
      fifo_full = ($urandom_range(99) < full_pct);
    end
    in_valid = ($urandom_range(99) < valid_pct);
    in_data  = (in_valid && is_pay) ? frame[m_ptr] : 8'($urandom);
    #1;
    busy_e = m_wait || active;
    drop_e = !busy_e && drv_req && (drv_len + OVH > BUCKET);
    acc_e  = m_wait && (m_tok >= m_len + OVH);
    wr_e   = active && !fifo_full && (!is_pay || in_valid);
    rdy_e  = is_pay && !fifo_full;
    chk("busy", busy, busy_e);
    chk("pkt_drop", pkt_drop, drop_e);
    chk("pkt_accept", pkt_accept, acc_e);
    chk("fifo_wr_en", fifo_wr_en, wr_e);
    chk("in_ready", in_ready, rdy_e);
    chk("tokens", tokens, m_tok);
    if (wr_e) chk("fifo_din", fifo_din, frame[m_ptr]);

    debit = 0;
    if (wr_e) begin
      m_ptr++;
      if (m_ptr == frame.size()) begin
        frame.delete();
        m_ptr = 0;
      end
    end
    if (drop_e) drv_req = 0;
    else if (!busy_e && drv_req) begin
      m_wait = 1;
      m_len  = drv_len;
      m_pay  = drv_pay;
    end
    if (acc_e) begin
      debit  = m_len + OVH;
      m_wait = 0;
      drv_req = 0;
      frame.delete();
      m_ptr = 0;
      frame.push_back(SOFB);
      frame.push_back(8'(m_len));
      cs = 8'h00;
      foreach (m_pay[i]) begin
        frame.push_back(m_pay[i]);
        cs ^= m_pay[i];
      end
      if (OVH == 3) frame.push_back(cs);
    end
    t = m_tok - debit + ((m_div == RDIV - 1) ? TPT : 0);
    m_tok = (t > BUCKET) ? BUCKET : t;
    m_div = (m_div + 1) % RDIV;
  endtask

  task automatic send(input int len, input int full_at, input int rst_at);
    bit full_done;
    full_done = 0;
    if (drv_pay.size() != len) begin
      drv_pay.delete();
      for (int i = 0; i < len; i++) drv_pay.push_back(8'($urandom));
    end
    drv_req = 1;
    drv_len = len;
    for (int c = 0; c < 3000; c++) begin
      if (full_at >= 0 && !full_done && frame.size() > 0 && m_ptr == full_at) begin
        full_force = 5;
        full_done  = 1;
      end
      if (rst_at >= 0 && frame.size() > 0 && m_ptr == rst_at) begin
        @(negedge clk);
        srst = 1'b1; pkt_start = 1'b0; in_valid = 1'b1; fifo_full = 1'b0;
        #1;
        chk("rst_busy", busy, 0);
        chk("rst_in_ready", in_ready, 0);
        chk("rst_fifo_wr_en", fifo_wr_en, 0);
        chk("rst_tokens", tokens, BUCKET);
        model_reset();
        drv_pay.delete();
        @(posedge clk);
        #1 srst = 1'b0;
        return;
      end
      step();
      if (!drv_req && !m_wait && frame.size() == 0) begin
        drv_pay.delete();
        return;
      end
    end
    chk("send_timeout", 1, 0);
    drv_pay.delete();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  initial begin
    srst = 1'b1; pkt_start = 1'b0; pkt_len = 8'd0; in_data = 8'd0;
    in_valid = 1'b0; fifo_full = 1'b0;
    model_reset();
    full_pct = 0; valid_pct = 100;
    repeat (2) @(negedge clk);
    #1;
    chk("reset_tokens", tokens, BUCKET);
    chk("reset_busy", busy, 0);
    chk("reset_fifo_wr_en", fifo_wr_en, 0);
    chk("reset_in_ready", in_ready, 0);
    chk("reset_pkt_accept", pkt_accept, 0);
    @(posedge clk);
    #1 srst = 1'b0;

    drv_pay.delete();
    drv_pay.push_back(8'h11); drv_pay.push_back(8'h22);
    drv_pay.push_back(8'h33); drv_pay.push_back(8'h44);
    send(4, -1, -1);
    idle(40);
    send(30, -1, -1);
    send(26, -1, -1);
    send(26, -1, -1);
    idle(140);
    send(10, 4, -1);
    idle(60);
    send(8, -1, 3);
    send(3, -1, -1);
    idle(20);
    send(0, -1, -1);
    idle(10);

    full_pct = 20; valid_pct = 70;
    for (int k = 0; k < 25; k++) begin
      send($urandom_range(0, 34), -1, -1);
      idle($urandom_range(0, 20));
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
